// File: rtl/adff_pipe_bank_pkg.sv
// Shared types and helpers for the async-reset pipeline bank.
// Defaults here seed the top-level parameters.
package adff_pipe_pkg;

  localparam int LANE_W    = 8;
  localparam int NCH_D     = 4;
  localparam int DEPTH_D   = 3;
  localparam int REL_CYC_D = 2;

  // Enough bits to count 0..n inclusive, never less than one.
  function automatic int rel_cw(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int REL_CW = rel_cw(REL_CYC_D);

  typedef struct packed {
    logic [LANE_W-1:0] bits;
  } lane_t;

  function automatic lane_t lane_mask(input lane_t data, input logic en, input lane_t rst_val);
    return en ? data : rst_val;
  endfunction

endpackage

// File: rtl/adff_pipe_bank_if.sv
// Producer/consumer bus of the pipeline bank.
// Both handshakes: a beat moves on a rising clk edge where valid && ready; valid never waits on ready.
interface adff_pipe_bank_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [NCH*WIDTH-1:0]   in_data;
  logic [NCH-1:0]         in_lane_en;
  logic                   out_valid;
  logic                   out_ready;
  logic [NCH*WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_lane_en, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_lane_en, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/adff_pipe_bank_stage.sv
// One pipeline stage: valid bit plus NCH lanes of data, async reset and sync flush to RST_VAL.
module adff_pipe_stage #(
  parameter int               WIDTH   = 8,
  parameter int               NCH     = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 load,
  input  logic                 d_valid,
  input  logic [NCH*WIDTH-1:0] d_data,
  output logic                 q_valid,
  output logic [NCH*WIDTH-1:0] q_data
);

  localparam logic [NCH*WIDTH-1:0] CLR_DATA = {NCH{RST_VAL}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_data  <= CLR_DATA;
    end else if (flush) begin
      q_valid <= 1'b0;
      q_data  <= CLR_DATA;
    end else if (load) begin
      q_valid <= d_valid;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/adff_pipe_bank.sv
// Multi-lane elastic register pipe: DEPTH stages, per-lane capture mask, flush,
// and a guard holding in_ready low for REL_CYC cycles after reset release.
module adff_pipe_bank
  import adff_pipe_pkg::*;
#(
  parameter int               WIDTH   = LANE_W,
  parameter int               NCH     = NCH_D,
  parameter int               DEPTH   = DEPTH_D,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               REL_CYC = REL_CYC_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  adff_pipe_bank_if.slave  bus
);

  localparam int BW = NCH * WIDTH;
  localparam int CW = (rel_cw(REL_CYC) > REL_CW) ? rel_cw(REL_CYC) : REL_CW;

  logic [CW-1:0]             rel_cnt;
  logic                      released;
  logic [DEPTH-1:0]          st_valid;
  logic [DEPTH-1:0]          load;
  logic [DEPTH-1:0][BW-1:0]  st_data;
  logic [BW-1:0]             masked;
  logic                      accept;

  // Saturates at REL_CYC; only rst_n re-arms it.
  assign released = (rel_cnt == CW'(REL_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_cnt <= '0;
    end else if (!released) begin
      rel_cnt <= rel_cnt + 1'b1;
    end
  end

  // Ready ripples from the consumer back to the input with no skid buffering.
  always_comb begin : ready_chain
    logic rdy;
    rdy  = bus.out_ready;
    load = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      load[k] = !st_valid[k] || rdy;
      rdy     = load[k];
    end
  end

  assign bus.in_ready = released && load[0];
  assign accept       = bus.in_valid && bus.in_ready;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    if (WIDTH == LANE_W) begin : g_pkg
      assign masked[i*WIDTH +: WIDTH] =
        lane_mask(lane_t'(bus.in_data[i*WIDTH +: WIDTH]), bus.in_lane_en[i], lane_t'(RST_VAL));
    end else begin : g_gen
      assign masked[i*WIDTH +: WIDTH] = bus.in_lane_en[i] ? bus.in_data[i*WIDTH +: WIDTH] : RST_VAL;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic          d_valid;
    logic [BW-1:0] d_data;

    if (k == 0) begin : g_head
      assign d_valid = accept;
      assign d_data  = masked;
    end else begin : g_body
      assign d_valid = st_valid[k-1];
      assign d_data  = st_data[k-1];
    end

    adff_pipe_stage #(
      .WIDTH   (WIDTH),
      .NCH     (NCH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .load    (load[k]),
      .d_valid (d_valid),
      .d_data  (d_data),
      .q_valid (st_valid[k]),
      .q_data  (st_data[k])
    );
  end

  assign bus.out_valid = st_valid[DEPTH-1];
  assign bus.out_data  = st_data[DEPTH-1];

endmodule

// File: tb/tb_adff_pipe_bank.sv
// Directed bench for adff_pipe_bank: vector table plus hand-written reset, backpressure and flush sequences.
module tb_adff_pipe_bank;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int BW = W * N;

  logic clk;
  logic rst_n;
  logic flush;

  adff_pipe_bank_if #(.WIDTH(W), .NCH(N)) bus ();

  adff_pipe_bank #(
    .WIDTH   (W),
    .NCH     (N),
    .DEPTH   (3),
    .RST_VAL (8'h00),
    .REL_CYC (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  int            n_cmp  = 0;
  int            n_fail = 0;
  int            cyc_no = 0;
  logic          obs_ir;
  logic          obs_ov;
  logic [BW-1:0] obs_od;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  function automatic logic [BW-1:0] mdl_mask(input logic [BW-1:0] d, input logic [N-1:0] en);
    logic [BW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = en[i] ? d[i*W +: W] : 8'h00;
    return r;
  endfunction

  // ---------------- driver ----------------
  // Drive at posedge+1, observe at negedge, advance to next posedge+1.
  task automatic cyc(input logic iv, input logic [BW-1:0] dat, input logic [N-1:0] en,
                     input logic ordy, input logic fl);
    bus.in_valid   = iv;
    bus.in_data    = dat;
    bus.in_lane_en = en;
    bus.out_ready  = ordy;
    flush          = fl;
    @(negedge clk);
    obs_ir = bus.in_ready;
    obs_ov = bus.out_valid;
    obs_od = bus.out_data;
    if (!fl) begin
      if (obs_ov && ordy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_unexpected: got %h expected no beat (cycle %0d)", obs_od, cyc_no);
        end else begin
          chk("sb_data", obs_od, exp_q.pop_front());
        end
      end
      if (iv && obs_ir) exp_q.push_back(mdl_mask(dat, en));
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    cyc_no++;
  endtask

  task automatic guard_seq(input string tag);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 4'hF, 1'b1, 1'b0);
      chk({tag, "_guard_ir"}, BW'(obs_ir), BW'(i == 2));
      chk({tag, "_guard_ov"}, BW'(obs_ov), '0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          iv;
    logic [BW-1:0] dat;
    logic [N-1:0]  en;
    logic          exp_ir;
    logic          exp_ov;
    logic          chk_d;
    logic [BW-1:0] exp_d;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int first_ov, last_ov, n_ov, acc_cyc;

    tbl[0] = '{1'b1, 32'hDDCCBBAA, 4'b0101, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h0,        4'b1111, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 32'h11223344, 4'b1111, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 32'h0,        4'b1111, 1'b1, 1'b1, 1'b1, 32'h00CC00AA};
    tbl[4] = '{1'b0, 32'h0,        4'b1111, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 32'h0,        4'b1111, 1'b1, 1'b1, 1'b1, 32'h11223344};
    tbl[6] = '{1'b1, 32'hDDCCBBAA, 4'b1010, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[7] = '{1'b0, 32'h0,        4'b1111, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[8] = '{1'b0, 32'h0,        4'b1111, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[9] = '{1'b0, 32'h0,        4'b1111, 1'b1, 1'b1, 1'b1, 32'hDD00BB00};

    // Power-on reset
    rst_n          = 1'b0;
    flush          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_lane_en = '0;
    bus.out_ready  = 1'b0;
    #2;
    chk("por_out_valid", BW'(bus.out_valid), '0);
    chk("por_in_ready",  BW'(bus.in_ready),  '0);
    chk("por_out_data",  bus.out_data,       '0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    guard_seq("por");

    // Table: lane masking and bubbles, out_ready held high
    for (int r = 0; r < 10; r++) begin
      cyc(tbl[r].iv, tbl[r].dat, tbl[r].en, 1'b1, 1'b0);
      chk($sformatf("tbl%0d_ir", r), BW'(obs_ir), BW'(tbl[r].exp_ir));
      chk($sformatf("tbl%0d_ov", r), BW'(obs_ov), BW'(tbl[r].exp_ov));
      if (tbl[r].chk_d) chk($sformatf("tbl%0d_od", r), obs_od, tbl[r].exp_d);
    end

    // Streaming 0x01..0x10 back-to-back
    first_ov = -1; last_ov = -1; n_ov = 0; acc_cyc = cyc_no;
    for (int b = 0; b < 22; b++) begin
      int idx;
      idx = cyc_no;
      cyc(b < 16, (b < 16) ? BW'(b + 1) * 32'h01010101 : '0, 4'hF, 1'b1, 1'b0);
      if (b < 16) chk("stream_ir", BW'(obs_ir), 32'h1);
      if (obs_ov) begin
        if (first_ov < 0) first_ov = idx;
        last_ov = idx;
        n_ov++;
      end
    end
    chk("stream_latency", BW'(first_ov - acc_cyc), 32'd3);
    chk("stream_count",   BW'(n_ov), 32'd16);
    chk("stream_no_gaps", BW'(last_ov - first_ov), 32'd15);
    chk("stream_drained", BW'(exp_q.size()), '0);

    // Backpressure: fill 3, stall, then pop and push in the same cycle
    cyc(1'b1, 32'hA1A1A1A1, 4'hF, 1'b0, 1'b0); chk("bp_ir0", BW'(obs_ir), 32'h1);
    cyc(1'b1, 32'hB2B2B2B2, 4'hF, 1'b0, 1'b0); chk("bp_ir1", BW'(obs_ir), 32'h1);
    cyc(1'b1, 32'hC3C3C3C3, 4'hF, 1'b0, 1'b0); chk("bp_ir2", BW'(obs_ir), 32'h1);
    cyc(1'b1, 32'hD4D4D4D4, 4'hF, 1'b0, 1'b0);
    chk("bp_full_ir", BW'(obs_ir), '0);
    chk("bp_full_ov", BW'(obs_ov), 32'h1);
    chk("bp_hold_od", obs_od, 32'hA1A1A1A1);
    cyc(1'b1, 32'hD4D4D4D4, 4'hF, 1'b0, 1'b0);
    chk("bp_still_od", obs_od, 32'hA1A1A1A1);
    cyc(1'b1, 32'hD4D4D4D4, 4'hF, 1'b1, 1'b0);
    chk("bp_pop_push_ir", BW'(obs_ir), 32'h1);
    chk("bp_pop_push_od", obs_od, 32'hA1A1A1A1);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 4'hF, 1'b1, 1'b0);
    chk("bp_empty_ov", BW'(obs_ov), '0);
    chk("bp_drained",  BW'(exp_q.size()), '0);

    // Flush with 3 beats stored; the handshake in the flush cycle is lost
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h5A5A5A00 + BW'(i), 4'hF, 1'b0, 1'b0);
    cyc(1'b1, 32'h77777777, 4'hF, 1'b1, 1'b1);
    exp_q.delete();
    #1;
    chk("flush_ov", BW'(bus.out_valid), '0);
    chk("flush_od", bus.out_data, '0);
    chk("flush_ir", BW'(bus.in_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 4'hF, 1'b1, 1'b0);
      chk("flush_lost_ov", BW'(obs_ov), '0);
    end

    // Async reset with 2 beats in flight
    cyc(1'b1, 32'h12345678, 4'hF, 1'b0, 1'b0);
    cyc(1'b1, 32'h9ABCDEF0, 4'hF, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ov", BW'(bus.out_valid), '0);
    chk("arst_od", bus.out_data, '0);
    chk("arst_ir", BW'(bus.in_ready), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    guard_seq("arst");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 4'hF, 1'b1, 1'b0);
      chk("arst_no_partial_ov", BW'(obs_ov), '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
